// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, debounce, held-key tracking.
// Optional macro KEYPAD_SHIFT_EN keeps the last four accepted keys on o_digits.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic [3:0]  o_col,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_key,
    output logic        o_valid,
    output logic        o_pressed,
    output logic [15:0] o_digits
);
    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  CNT_DONE  = 8'(DEBOUNCE_CNT);

    state_t      state_q, state_d;
    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] slot_q;
    logic [1:0]  col_q, col_d;
    logic [3:0]  cand_q, cand_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic        valid_q, valid_d;
    logic        pressed_q, pressed_d;
    logic        sample;
    logic        one_low;
    logic        all_high;
    logic        accept;
    logic [3:0]  code;

    function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [1:0] col);
        logic [1:0] r;
        case (rows)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({r, col})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = 4'hC;
            4'hC: key_code = 4'h0;
            4'hD: key_code = 4'hF;
            4'hE: key_code = 4'hE;
            default: key_code = 4'hD;
        endcase
    endfunction

    assign sample   = (slot_q == SLOT_LAST);
    assign one_low  = ($countones(~row_sync_q) == 1);
    assign all_high = (row_sync_q == 4'hF);
    // A candidate always equals the current sample when accepted, so decode from it directly.
    assign code     = key_code(row_sync_q, col_q);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        accept    = 1'b0;
        if (sample) begin
            case (state_q)
                S_SCAN: begin
                    if (one_low) begin
                        cand_d = row_sync_q;
                        cnt_d  = 8'd1;
                        if (CNT_DONE == 8'd1) accept = 1'b1;
                        else                  state_d = S_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (row_sync_q == cand_q) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == CNT_DONE) accept = 1'b1;
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (all_high) begin
                        cnt_d = 8'd1;
                        if (CNT_DONE == 8'd1) begin
                            pressed_d = 1'b0;
                            col_d     = col_q + 2'd1;
                            state_d   = S_SCAN;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (all_high) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == CNT_DONE) begin
                            pressed_d = 1'b0;
                            col_d     = col_q + 2'd1;
                            state_d   = S_SCAN;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
        if (accept) begin
            key_d     = code;
            valid_d   = 1'b1;
            pressed_d = 1'b1;
            state_d   = S_HELD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            slot_q     <= '0;
            state_q    <= S_SCAN;
            col_q      <= '0;
            cand_q     <= 4'hF;
            cnt_q      <= '0;
            key_q      <= '0;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            row_meta_q <= i_row;
            row_sync_q <= row_meta_q;
            slot_q     <= sample ? '0 : slot_q + 16'd1;
            state_q    <= state_d;
            col_q      <= col_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            pressed_q  <= pressed_d;
        end
    end

`ifdef KEYPAD_SHIFT_EN
    logic [15:0] digits_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn)     digits_q <= '0;
        else if (accept) digits_q <= {digits_q[11:0], code};
    end

    assign o_digits = digits_q;
`else
    assign o_digits = {12'h000, key_q};
`endif

    assign o_col     = ~(4'b0001 << col_q);
    assign o_key     = key_q;
    assign o_valid   = valid_q;
    assign o_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical 4x4 switch matrix drives i_row from o_col, and
// a key-history model predicts accepted keys, o_digits, timing and scan order.
module tb_keypad_scan_ctrl;
    localparam int SD          = 4;
    localparam int DB          = 3;
    // Valid is counted on the edge after it is raised, hence the extra cycle.
    localparam int LAT_MAX     = 2 + SD * (4 + DB) + 1;
    localparam int LAT_ALIGNED = DB * SD + 1;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [3:0]  o_col;
    logic [3:0]  i_row;
    logic [3:0]  o_key;
    logic        o_valid;
    logic        o_pressed;
    logic [15:0] o_digits;

    bit          btn [4][4];
    logic [3:0]  keymap [16];
    int          n_assert = 0;
    int          n_fail = 0;
    int          vcount = 0;
    int          kcnt = 0;
    logic [15:0] exp_digits = '0;
    logic [3:0]  exp_key = '0;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .o_col    (o_col),
        .i_row    (i_row),
        .o_key    (o_key),
        .o_valid  (o_valid),
        .o_pressed(o_pressed),
        .o_digits (o_digits)
    );

    always #5 i_clk = ~i_clk;

    // A closed switch pulls its row low only while its column is driven low.
    always_comb begin
        i_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (btn[r][c] && !o_col[c]) i_row[r] = 1'b0;
    end

    always @(posedge i_clk) begin
        if (o_valid === 1'b1) vcount <= vcount + 1;
        kcnt <= i_rstn ? kcnt + 1 : 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1);
    end

    function automatic logic [3:0] col_pat(input int c);
        col_pat = ~(4'b0001 << c);
    endfunction

    function automatic logic [15:0] digits_view();
`ifdef KEYPAD_SHIFT_EN
        return exp_digits;
`else
        return {12'h000, exp_key};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic model_accept(input logic [3:0] code);
        exp_key    = code;
        exp_digits = {exp_digits[11:0], code};
    endtask

    // Returns just after the column turns to target, i.e. right after a sample edge.
    task automatic wait_col(input logic [3:0] target);
        int n = 0;
        while (o_col === target && n < 40) begin cyc(1); n++; end
        while (o_col !== target && n < 40) begin cyc(1); n++; end
        chk("col_reach", {28'd0, o_col}, {28'd0, target});
    endtask

    task automatic wait_valid(input int v0, input int limit, output int lat);
        lat = 0;
        while (vcount == v0 && lat < limit) begin cyc(1); lat++; end
    endtask

    task automatic press_check(input int r, input int c, input bit aligned);
        int lat;
        int v0;
        if (aligned) wait_col(col_pat(c));
        v0 = vcount;
        btn[r][c] = 1'b1;
        wait_valid(v0, LAT_MAX + 8, lat);
        model_accept(keymap[r * 4 + c]);
        chk("valid_once", vcount - v0, 1);
        if (aligned) chk("lat_exact", lat, LAT_ALIGNED);
        else         chk("lat_bound", {31'd0, lat <= LAT_MAX}, 1);
        chk("key", {28'd0, o_key}, {28'd0, exp_key});
        chk("digits", {16'd0, o_digits}, {16'd0, digits_view()});
        chk("pressed", {31'd0, o_pressed}, 1);
        cyc(40);
        chk("no_repeat", vcount - v0, 1);
        chk("held_col", {28'd0, o_col}, {28'd0, col_pat(c)});
        chk("pressed_hold", {31'd0, o_pressed}, 1);
        btn[r][c] = 1'b0;
        cyc(4);
        chk("pressed_release_early", {31'd0, o_pressed}, 1);
        cyc(24);
        chk("pressed_released", {31'd0, o_pressed}, 0);
        chk("release_no_valid", vcount - v0, 1);
        chk("key_kept", {28'd0, o_key}, {28'd0, exp_key});
    endtask

    task automatic burst(input int n_on);
        wait_col(col_pat(1));
        btn[1][1] = 1'b1;
        cyc(SD * n_on);
        btn[1][1] = 1'b0;
        cyc(SD * 2);
    endtask

    initial begin
        int v0;
        int lat;
        int idx;
        logic [3:0] seen;
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

        // Reset state
        cyc(3);
        chk("rst_col", {28'd0, o_col}, 32'hE);
        chk("rst_key", {28'd0, o_key}, 0);
        chk("rst_valid", {31'd0, o_valid}, 0);
        chk("rst_pressed", {31'd0, o_pressed}, 0);
        chk("rst_digits", {16'd0, o_digits}, 0);
        i_rstn = 1'b1;

        // Idle scan order
        for (int k = 0; k < 64; k++) begin
            cyc(1);
            chk("scan_col", {28'd0, o_col}, {28'd0, col_pat((kcnt / SD) % 4)});
        end
        chk("idle_no_valid", vcount, 0);

        // Key 6, single accept, held, released
        press_check(1, 2, 1'b1);
        chk("key6_digits", {16'd0, o_digits}, 32'h0006);

        // Sequence 1, 2, 3, A
        v0 = vcount;
        press_check(0, 0, 1'b1);
        press_check(0, 1, 1'b1);
        press_check(0, 2, 1'b1);
        press_check(0, 3, 1'b1);
        chk("seq_pulses", vcount - v0, 4);
`ifdef KEYPAD_SHIFT_EN
        chk("seq_digits", {16'd0, o_digits}, 32'h123A);
`else
        chk("seq_digits", {16'd0, o_digits}, 32'h000A);
`endif

        // Bouncing key 5 never reaches the debounce count
        v0 = vcount;
        burst(1);
        burst(1);
        burst(2);
        burst(2);
        chk("bounce_no_valid", vcount - v0, 0);
        chk("bounce_not_pressed", {31'd0, o_pressed}, 0);
        press_check(1, 1, 1'b1);

        // Ghost: rows 0 and 2 low in column 0
        v0 = vcount;
        btn[0][0] = 1'b1;
        btn[2][0] = 1'b1;
        cyc(80);
        chk("ghost_no_valid", vcount - v0, 0);
        seen = 4'h0;
        for (int k = 0; k < 4 * SD; k++) begin
            seen |= ~o_col;
            cyc(1);
        end
        chk("ghost_scanning", {28'd0, seen}, 32'hF);
        btn[0][0] = 1'b0;
        btn[2][0] = 1'b0;
        cyc(8);

        // Random keys, unaligned
        for (int i = 0; i < 6; i++) begin
            idx = $urandom_range(0, 15);
            cyc($urandom_range(0, 7));
            press_check(idx / 4, idx % 4, 1'b0);
        end

        // Reset during debounce of key 9, then fresh detection
        wait_col(col_pat(2));
        v0 = vcount;
        btn[2][2] = 1'b1;
        cyc(SD + 2);
        chk("deb_frozen", {28'd0, o_col}, {28'd0, col_pat(2)});
        i_rstn = 1'b0;
        cyc(2);
        exp_digits = '0;
        exp_key    = '0;
        chk("mid_rst_col", {28'd0, o_col}, 32'hE);
        chk("mid_rst_key", {28'd0, o_key}, 0);
        chk("mid_rst_valid", {31'd0, o_valid}, 0);
        chk("mid_rst_pressed", {31'd0, o_pressed}, 0);
        chk("mid_rst_digits", {16'd0, o_digits}, 0);
        chk("mid_rst_no_valid", vcount - v0, 0);
        i_rstn = 1'b1;
        wait_valid(v0, LAT_MAX + 8, lat);
        model_accept(4'h9);
        chk("post_rst_valid", vcount - v0, 1);
        chk("post_rst_lat", {31'd0, lat <= LAT_MAX}, 1);
        chk("post_rst_key", {28'd0, o_key}, 32'h9);
        chk("post_rst_digits", {16'd0, o_digits}, {16'd0, digits_view()});
        chk("post_rst_pressed", {31'd0, o_pressed}, 1);
        btn[2][2] = 1'b0;
        cyc(30);
        chk("post_rst_released", {31'd0, o_pressed}, 0);
        chk("post_rst_single", vcount - v0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16, clock cycles per column slot / per sample (legal range 4..65535).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, consecutive identical samples required to accept a press or a release (legal range 1..255).
REQ-003 SHALL have port i_clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port i_rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port o_col  output  4  column drive, active-low, exactly one bit low at a time.
REQ-006 SHALL have port i_row  input  4  row sense, active-low (externally pulled up), asynchronous.
REQ-007 SHALL have port o_key  output  4  hex code of the last accepted key, held until the next accepted key.
REQ-008 SHALL have port o_valid  output  1  one-cycle pulse when a key is accepted.
REQ-009 SHALL have port o_pressed  output  1  high while an accepted key is held.
REQ-010 SHALL have port o_digits  output  16  last four accepted keys, newest in [3:0]; drives a 4-digit hex display directly.

Function
REQ-011 SHALL pass i_row through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-012 SHALL use a slot counter of 0..SCAN_DIV-1 and sample the synchronized rows when the counter equals SCAN_DIV-1; the counter then wraps to 0.
REQ-013 SHALL use column index c (0..3) with o_col = ~(1<<c); in SCAN, c SHALL advance with wrap 3->0 after each sample.
REQ-014 SHALL map (row r, column c) to o_key as follows: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D (c0..c3 left to right).
REQ-015 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 In SCAN, a sample with exactly one row low SHALL latch candidate (r,c), freeze c, set the match count to 1, and enter DEBOUNCE; if DEBOUNCE_CNT=1, SHALL accept immediately per REQ-018.
REQ-017 In SCAN, a sample with zero rows low or two or more rows low (ghost/multi-key) SHALL be ignored, and c SHALL advance.
REQ-018 In DEBOUNCE, a sample equal to the candidate pattern SHALL increment the count; on reaching DEBOUNCE_CNT the block SHALL accept: o_key=code, o_valid=1 for exactly the next cycle, o_digits={o_digits[11:0],code}, o_pressed=1, state HELD.
REQ-019 In DEBOUNCE, any differing sample SHALL discard the candidate, advance c, and return to SCAN without o_valid.
REQ-020 In HELD, c SHALL stay frozen; an all-high sample SHALL enter RELEASE with count 1; no auto-repeat SHALL occur.
REQ-021 In RELEASE, all-high samples SHALL count to DEBOUNCE_CNT, then o_pressed=0, c advances, state SCAN; any low row sample SHALL return to HELD without a new o_valid.
REQ-022 Acceptance latency SHALL be at most 2 + SCAN_DIV*(4+DEBOUNCE_CNT) cycles after a stable press.

Reset
REQ-023 While i_rstn=0 at a clock edge: state=SCAN, c=0 (o_col=4'b1110), slot counter=0, synchronizer=4'hF, o_key=0, o_valid=0, o_pressed=0, o_digits=0.
REQ-024 Reset mid-press SHALL abort without o_valid; a key still held after reset SHALL be detected anew and produce a fresh o_valid.

Configuration
REQ-025 Macro KEYPAD_SHIFT_EN defined: o_digits SHALL behave per REQ-018.
REQ-026 Macro KEYPAD_SHIFT_EN undefined: o_digits SHALL be {12'h000,o_key}, and no shift register SHALL be synthesized.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, KEYPAD_SHIFT_EN defined)
REQ-027 Reset, no press, 64 cycles -> o_col cycles 1110,1101,1011,0111 every 4 cycles; o_valid never 1.
REQ-028 Hold row1 low whenever c=2 (key 6) -> single o_valid with o_key=4'h6, o_digits=16'h0006, o_pressed=1 until release.
REQ-029 Press 1, 2, 3, A sequentially, each with a full release -> o_digits=16'h123A; exactly four o_valid pulses.
REQ-030 Bounce: row toggles on alternate samples during DEBOUNCE -> no o_valid; a subsequent stable hold yields exactly one.
REQ-031 Two rows low in the same column (rows 0 and 2 at c0) -> no o_valid; scanning continues.
REQ-032 Assert i_rstn=0 during DEBOUNCE for key 9 -> outputs per REQ-023; the held key then produces o_valid with o_key=4'h9.
